// File: rtl/code_decoder_stream.sv
// Stream decoder for 7-bit Gray/one-hot code words. It has a registered 1-entry output stage and counts illegal words.
// Optional GRAY_STEP_CHECK_EN: counts accepted legal values that do not step by +1 mod 8.
module code_decoder_stream #(
    parameter int unsigned USE_GRAY = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] step_err_cnt
);

    logic        accept;
    logic [2:0]  dec_data;
    logic        dec_err;
    logic [2:0]  oh_idx;
    int unsigned oh_ones;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_data = '0;
        dec_err  = 1'b0;
        oh_idx   = '0;
        oh_ones  = 0;
        if (USE_GRAY != 0) begin
            dec_data[2] = in_code[2];
            dec_data[1] = in_code[2] ^ in_code[1];
            dec_data[0] = ^in_code[2:0];
            if (in_code[6:3] != '0) begin
                dec_err  = 1'b1;
                dec_data = '0;
            end
        end else begin
            for (int unsigned k = 0; k < 7; k++) begin
                if (in_code[k]) begin
                    oh_ones++;
                    oh_idx = 3'(k + 1);
                end
            end
            // All-zero word decodes to 0; more than one set bit is illegal.
            if (oh_ones > 1) begin
                dec_err = 1'b1;
            end else begin
                dec_data = oh_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= dec_data;
            out_err   <= dec_err;
            if (dec_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [2:0] last_val;
    logic       hist_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_val     <= '0;
            hist_valid   <= 1'b0;
            step_err_cnt <= '0;
        end else if (accept && !dec_err) begin
            last_val   <= dec_data;
            hist_valid <= 1'b1;
            // 3-bit compare makes the 7->0 wrap a legal step.
            if (hist_valid && (dec_data != last_val + 3'd1) && (step_err_cnt != '1)) begin
                step_err_cnt <= step_err_cnt + 1'b1;
            end
        end
    end
`else
    assign step_err_cnt = '0;
`endif

endmodule

// File: tb/tb_code_decoder_stream.sv
// Self-checking bench: a Gray and a one-hot instance are driven with the same stimulus.
// It applies vector tables, hand-written corner sequences, and random traffic checked against a reference model.
module tb_code_decoder_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] in_code = '0;
    logic       out_ready = 1'b0;

    logic       g_in_ready, g_out_valid, g_out_err;
    logic [2:0] g_out_data;
    logic [7:0] g_err_cnt, g_step_cnt;
    logic       o_in_ready, o_out_valid, o_out_err;
    logic [2:0] o_out_data;
    logic [7:0] o_err_cnt, o_step_cnt;

    int total = 0;
    int passed = 0;

`ifdef GRAY_STEP_CHECK_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    code_decoder_stream #(.USE_GRAY(1), .CNT_W(8)) dut_g (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(g_in_ready),
        .in_code(in_code), .out_valid(g_out_valid), .out_ready(out_ready),
        .out_data(g_out_data), .out_err(g_out_err), .err_cnt(g_err_cnt),
        .step_err_cnt(g_step_cnt)
    );

    code_decoder_stream #(.USE_GRAY(0), .CNT_W(8)) dut_o (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_in_ready),
        .in_code(in_code), .out_valid(o_out_valid), .out_ready(out_ready),
        .out_data(o_out_data), .out_err(o_out_err), .err_cnt(o_err_cnt),
        .step_err_cnt(o_step_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [6:0] gray_of(input int v);
        logic [6:0] g;
        g = 7'(v ^ (v >> 1));
        return g;
    endfunction

    // Reference decode by table search (Gray) or single-bit position (one-hot).
    task automatic ref_decode(input int inst, input logic [6:0] code, output int v, output bit ill);
        v = 0;
        ill = 1'b0;
        if (inst == 0) begin
            if (code[6:3] != 0) ill = 1'b1;
            else for (int b = 0; b < 8; b++) if (gray_of(b) == code) v = b;
        end else begin
            if (code == 0) v = 0;
            else if ($countones(code) == 1) begin
                for (int k = 0; k < 7; k++) if (code == 7'(1 << k)) v = k + 1;
            end else ill = 1'b1;
        end
    endtask

    task automatic get_out(input int inst, output int rdy, output int ov, output int d,
                           output int e, output int ec, output int sc);
        if (inst == 0) begin
            rdy = g_in_ready; ov = g_out_valid; d = g_out_data; e = g_out_err;
            ec = g_err_cnt; sc = g_step_cnt;
        end else begin
            rdy = o_in_ready; ov = o_out_valid; d = o_out_data; e = o_out_err;
            ec = o_err_cnt; sc = o_step_cnt;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input logic [6:0] code);
        in_valid = 1'b1;
        in_code = code;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    typedef struct {
        bit         rst_before;
        int         inst;
        logic [6:0] code;
        int         data;
        int         err;
        int         errc;
    } vec_t;

    vec_t vecs[$];

    bit m_ov[2];
    int m_data[2], m_err[2], m_errc[2], m_step[2], m_last[2];
    bit m_hv[2];

    initial begin
        int rdy, ov, d, e, ec, sc, v;
        bit ill;
        bit acc[2];

        vecs.push_back('{1'b1, 0, gray_of(0), 0, 0, 0});
        for (int i = 1; i < 8; i++) vecs.push_back('{1'b0, 0, gray_of(i), i, 0, 0});
        vecs.push_back('{1'b0, 0, 7'b0001011, 0, 1, 1});
        vecs.push_back('{1'b0, 0, 7'b0000011, 2, 0, 1});
        vecs.push_back('{1'b1, 1, 7'b0000000, 0, 0, 0});
        vecs.push_back('{1'b0, 1, 7'b0000100, 3, 0, 0});
        vecs.push_back('{1'b0, 1, 7'b1000000, 7, 0, 0});
        vecs.push_back('{1'b0, 1, 7'b0000110, 0, 1, 1});
        vecs.push_back('{1'b0, 1, 7'b0000001, 1, 0, 1});
        vecs.push_back('{1'b0, 1, 7'b1100000, 0, 1, 2});

        do_reset();
        get_out(0, rdy, ov, d, e, ec, sc);
        check("reset_g_out_valid", ov, 0);
        check("reset_g_out_data", d, 0);
        check("reset_g_err_cnt", ec, 0);
        check("reset_g_in_ready", rdy, 1);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            send(vecs[i].code);
            get_out(vecs[i].inst, rdy, ov, d, e, ec, sc);
            check($sformatf("vec%0d_valid", i), ov, 1);
            check($sformatf("vec%0d_data", i), d, vecs[i].data);
            check($sformatf("vec%0d_err", i), e, vecs[i].err);
            check($sformatf("vec%0d_errcnt", i), ec, vecs[i].errc);
        end
        @(posedge clk); #1;
        check("drain_out_valid", g_out_valid, 0);

        // Saturation of the illegal-word counter.
        do_reset();
        in_valid = 1'b1; in_code = 7'b1111111; out_ready = 1'b1;
        repeat (254) @(posedge clk);
        #1 check("errcnt_254", g_err_cnt, 254);
        check("errcnt_254_oh", o_err_cnt, 254);
        repeat (46) @(posedge clk);
        #1 check("errcnt_sat", g_err_cnt, 255);
        check("errcnt_sat_oh", o_err_cnt, 255);
        in_valid = 1'b0;

        // Backpressure, then no-bubble resume.
        do_reset();
        send(gray_of(3));
        out_ready = 1'b0; in_valid = 1'b1; in_code = gray_of(5);
        #1 check("bp_in_ready", g_in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_data", i), g_out_data, 3);
            check($sformatf("bp_hold%0d_valid", i), g_out_valid, 1);
        end
        out_ready = 1'b1;
        #1 check("bp_ready_again", g_in_ready, 1);
        @(posedge clk); #1;
        check("bp_next_data", g_out_data, 5);
        check("bp_next_valid", g_out_valid, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_drained", g_out_valid, 0);

        // Step check: 6,7,0,2 -> only 0->2 is a violation.
        do_reset();
        send(gray_of(6)); send(gray_of(7)); send(gray_of(0)); send(gray_of(2));
        check("step_6702", g_step_cnt, STEP_EN ? 1 : 0);

        // Reset while an output word is held under backpressure.
        do_reset();
        send(7'b0001011);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("held_valid", g_out_valid, 1);
        check("held_errcnt", g_err_cnt, 1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_valid", g_out_valid, 0);
        check("async_rst_data", g_out_data, 0);
        check("async_rst_err", g_out_err, 0);
        check("async_rst_errcnt", g_err_cnt, 0);
        check("async_rst_stepcnt", g_step_cnt, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        send(gray_of(5));
        check("post_rst_first_step", g_step_cnt, 0);
        send(gray_of(6));
        check("post_rst_good_step", g_step_cnt, 0);
        send(gray_of(0));
        check("post_rst_bad_step", g_step_cnt, STEP_EN ? 1 : 0);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            m_ov[i] = 0; m_data[i] = 0; m_err[i] = 0; m_errc[i] = 0;
            m_step[i] = 0; m_last[i] = 0; m_hv[i] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            int sel;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 3);
            if (sel <= 1) in_code = gray_of($urandom_range(0, 7));
            else if (sel == 2) in_code = ($urandom_range(0, 7) == 7) ? 7'd0 : 7'(1 << $urandom_range(0, 6));
            else in_code = 7'($urandom);
            #1;
            for (int i = 0; i < 2; i++) begin
                get_out(i, rdy, ov, d, e, ec, sc);
                check($sformatf("rnd%0d_i%0d_in_ready", cyc, i), rdy, (!m_ov[i] || out_ready) ? 1 : 0);
                acc[i] = in_valid && (!m_ov[i] || out_ready);
            end
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    ref_decode(i, in_code, v, ill);
                    m_ov[i] = 1; m_data[i] = v; m_err[i] = ill;
                    if (ill) m_errc[i] = (m_errc[i] < 255) ? m_errc[i] + 1 : 255;
                    else begin
                        if (STEP_EN && m_hv[i] && v != (m_last[i] + 1) % 8)
                            m_step[i] = (m_step[i] < 255) ? m_step[i] + 1 : 255;
                        m_last[i] = v; m_hv[i] = 1;
                    end
                end else if (out_ready) m_ov[i] = 0;
                get_out(i, rdy, ov, d, e, ec, sc);
                check($sformatf("rnd%0d_i%0d_valid", cyc, i), ov, m_ov[i]);
                if (m_ov[i]) begin
                    check($sformatf("rnd%0d_i%0d_data", cyc, i), d, m_data[i]);
                    check($sformatf("rnd%0d_i%0d_err", cyc, i), e, m_err[i]);
                end
                check($sformatf("rnd%0d_i%0d_errcnt", cyc, i), ec, m_errc[i]);
                check($sformatf("rnd%0d_i%0d_stepcnt", cyc, i), sc, m_step[i]);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
